// File: rtl/spi_regmem_pkg.sv
// Shared types for the SPI slave register memory: command opcodes, FSM states
// and the command-word width derivation.
package spi_regmem_pkg;

    typedef enum logic [2:0] {
        OP_WR  = 3'b001,
        OP_RD  = 3'b010,
        OP_BWR = 3'b011,
        OP_BRD = 3'b100
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_e;

    // Three opcode bits followed by the address
    function automatic int cmd_width(input int addr_w);
        return 3 + addr_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with single-cycle rise/fall
// pulses taken from the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic              level;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {STAGES{RST_VAL}};
            prev_reg <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_slave_regmem.sv
// SPI mode-0 slave giving single/burst access to a register memory that is
// shared with a parallel host port; SPI accesses win arbitration.
module spi_slave_regmem
    import spi_regmem_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int BURST_WRAP  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              host_en,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ready,
    output logic              spi_wr_pulse,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic              frame_err,
    output logic              busy
);

    localparam int CMD_W = cmd_width(ADDR_W);
    localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(SH_W) + 1;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   mosi_bit;

    // cs chain resets low so a frame only starts after a real high-to-low edge
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk(clk), .srst(rst), .d(cs), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .srst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) mosi_sync_reg <= '0;
        else     mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_bit = mosi_sync_reg[SYNC_STAGES-1];

    state_e              state_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [SH_W-2:0]     shift_in_reg;
    logic [SH_W-1:0]     next_in;
    logic [DATA_W-1:0]   shift_out_reg;
    logic [ADDR_W-1:0]   addr_reg, rd_addr_reg, wr_addr_reg;
    logic [2:0]          op_reg, cmd_op;
    logic [DATA_W-1:0]   wdata_reg, host_rdata_reg;
    logic                rd_load_reg, wr_pulse_reg, miso_reg, miso_oe_reg;
    logic                frame_err_reg, busy_reg;
    logic                last_cmd, last_data, burst_stop, spi_access, host_wr;
    logic [DATA_W-1:0]   mem_reg [DEPTH];

    assign next_in    = {shift_in_reg, mosi_bit};
    assign cmd_op     = next_in[CMD_W-1 -: 3];
    assign last_cmd   = (bit_cnt_reg == CNT_W'(CMD_W - 1));
    assign last_data  = (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign burst_stop = (BURST_WRAP == 0) && (addr_reg == TOP_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_in_reg  <= '0;
            shift_out_reg <= '0;
            addr_reg      <= '0;
            rd_addr_reg   <= '0;
            wr_addr_reg   <= '0;
            op_reg        <= '0;
            wdata_reg     <= '0;
            rd_load_reg   <= 1'b0;
            wr_pulse_reg  <= 1'b0;
            miso_reg      <= 1'b0;
            miso_oe_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            wr_pulse_reg  <= 1'b0;
            rd_load_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            if (rd_load_reg) shift_out_reg <= mem_reg[rd_addr_reg];
            if (cs_rise) begin
                state_reg     <= ST_IDLE;
                miso_reg      <= 1'b0;
                miso_oe_reg   <= 1'b0;
                busy_reg      <= 1'b0;
                frame_err_reg <= (state_reg == ST_CMD || state_reg == ST_WDATA) &&
                                 (bit_cnt_reg != '0);
            end else begin
                case (state_reg)
                    ST_IDLE: if (cs_fall) begin
                        state_reg   <= ST_CMD;
                        bit_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                    ST_CMD: if (sclk_rise) begin
                        shift_in_reg <= next_in[SH_W-2:0];
                        if (last_cmd) begin
                            bit_cnt_reg <= '0;
                            op_reg      <= cmd_op;
                            addr_reg    <= next_in[ADDR_W-1:0];
                            case (cmd_op)
                                OP_WR, OP_BWR: state_reg <= ST_WDATA;
                                OP_RD, OP_BRD: begin
                                    state_reg   <= ST_RDATA;
                                    rd_load_reg <= 1'b1;
                                    rd_addr_reg <= next_in[ADDR_W-1:0];
                                end
                                default: state_reg <= ST_DONE;
                            endcase
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_WDATA: if (sclk_rise) begin
                        shift_in_reg <= next_in[SH_W-2:0];
                        if (last_data) begin
                            bit_cnt_reg  <= '0;
                            wr_pulse_reg <= 1'b1;
                            wr_addr_reg  <= addr_reg;
                            wdata_reg    <= next_in[DATA_W-1:0];
                            if (op_reg == OP_BWR && !burst_stop) addr_reg  <= addr_reg + ADDR_W'(1);
                            else                                 state_reg <= ST_DONE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_RDATA: begin
                        // The first falling edge after the command presents the MSB
                        if (sclk_fall) begin
                            miso_reg      <= shift_out_reg[DATA_W-1];
                            miso_oe_reg   <= 1'b1;
                            shift_out_reg <= {shift_out_reg[DATA_W-2:0], 1'b0};
                        end else if (sclk_rise) begin
                            if (last_data) begin
                                bit_cnt_reg <= '0;
                                if (op_reg == OP_BRD && !burst_stop) begin
                                    addr_reg    <= addr_reg + ADDR_W'(1);
                                    rd_addr_reg <= addr_reg + ADDR_W'(1);
                                    rd_load_reg <= 1'b1;
                                end else begin
                                    state_reg   <= ST_DONE;
                                    miso_reg    <= 1'b0;
                                    miso_oe_reg <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // SPI commit and SPI read-load cycles own the memory port
    assign spi_access = wr_pulse_reg | rd_load_reg;
    assign host_ready = host_en & ~rst & ~spi_access;
    assign host_wr    = host_ready & host_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (wr_pulse_reg) begin
            mem_reg[wr_addr_reg] <= wdata_reg;
        end else if (host_wr) begin
            mem_reg[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         host_rdata_reg <= '0;
        else if (host_ready && !host_we) host_rdata_reg <= mem_reg[host_addr];
    end

    assign miso         = miso_reg & miso_oe_reg;
    assign miso_oe      = miso_oe_reg;
    assign host_rdata   = host_rdata_reg;
    assign spi_wr_pulse = wr_pulse_reg;
    assign spi_wr_addr  = wr_addr_reg;
    assign frame_err    = frame_err_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_spi_slave_regmem.sv
// Directed plus randomized bench for spi_slave_regmem: dut0 stops bursts at the
// top address, dut1 wraps; both are checked against an array-level memory model.
module tb_spi_slave_regmem;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int HALF  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs0 = 1'b1, cs1 = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic host_en = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;

    logic miso0, miso_oe0, host_ready0, spi_wr_pulse0, frame_err0, busy0;
    logic [AW-1:0] spi_wr_addr0;
    logic [DW-1:0] host_rdata0;
    logic miso1, miso_oe1, host_ready1, spi_wr_pulse1, frame_err1, busy1;
    logic [AW-1:0] spi_wr_addr1;
    logic [DW-1:0] host_rdata1;

    always #5 clk = ~clk;

    spi_slave_regmem #(.ADDR_W(AW), .DATA_W(DW), .BURST_WRAP(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .cs(cs0), .sclk(sclk), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata0), .host_ready(host_ready0),
        .spi_wr_pulse(spi_wr_pulse0), .spi_wr_addr(spi_wr_addr0),
        .frame_err(frame_err0), .busy(busy0)
    );

    spi_slave_regmem #(.ADDR_W(AW), .DATA_W(DW), .BURST_WRAP(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .cs(cs1), .sclk(sclk), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1),
        .host_en(1'b0), .host_we(1'b0), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata1), .host_ready(host_ready1),
        .spi_wr_pulse(spi_wr_pulse1), .spi_wr_addr(spi_wr_addr1),
        .frame_err(frame_err1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters written only by the monitor
    logic [AW-1:0] act_wr[$];
    int err_cnt = 0, oe_cnt0 = 0, oe_cnt1 = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (spi_wr_pulse0) act_wr.push_back(spi_wr_addr0);
        if (frame_err0)    err_cnt++;
        if (miso_oe0)      oe_cnt0++;
        if (miso_oe1)      oe_cnt1++;
        if (busy0)         busy_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    logic [DW-1:0] model [2][DEPTH];
    logic [DW-1:0] tx_words [4];
    logic [DW-1:0] rx_words [4];
    logic [DW-1:0] exp_rx [4];
    logic [AW-1:0] exp_wr[$];
    int wr_idx = 0;
    int err_base, oe_base0, oe_base1, busy_base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input int sel, input logic b, output logic r);
        mosi = b;
        repeat (HALF) @(negedge clk);
        r = (sel == 0) ? miso0 : miso1;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input int sel, input logic [7:0] cmd, input int nwords, input int part);
        logic r;
        if (sel == 0) cs0 = 1'b0; else cs1 = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(sel, cmd[i], r);
        for (int w = 0; w < nwords; w++)
            for (int b = DW - 1; b >= 0; b--) begin
                spi_bit(sel, tx_words[w][b], r);
                rx_words[w][b] = r;
            end
        for (int p = 0; p < part; p++) spi_bit(sel, 1'($urandom), r);
        repeat (4) @(negedge clk);
        cs0 = 1'b1;
        cs1 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Expected effect of a whole frame on the memory, read data and commit list
    task automatic frame_pre(input int sel, input logic [7:0] cmd, input int nwords);
        int op, a, aa;
        op = int'(cmd[7:5]);
        a  = int'(cmd[4:0]);
        for (int w = 0; w < 4; w++) exp_rx[w] = '0;
        for (int w = 0; w < nwords; w++) begin
            aa = a + w;
            if ((op == 1 || op == 2) && w > 0) break;
            if (aa >= DEPTH) begin
                if (sel == 1) aa -= DEPTH;
                else break;
            end
            if (op == 1 || op == 3) begin
                model[sel][aa] = tx_words[w];
                if (sel == 0) exp_wr.push_back(AW'(aa));
            end else if (op == 2 || op == 4) begin
                exp_rx[w] = model[sel][aa];
            end
        end
        err_base  = err_cnt;
        oe_base0  = oe_cnt0;
        oe_base1  = oe_cnt1;
        busy_base = busy_cnt;
    endtask

    task automatic frame_post(input string tag, input int sel, input logic [7:0] cmd,
                              input int nwords, input int part);
        int op, oe_delta;
        op = int'(cmd[7:5]);
        for (int w = 0; w < nwords; w++)
            check($sformatf("%s_rx%0d", tag, w), rx_words[w], exp_rx[w]);
        check({tag, "_wrcnt"}, act_wr.size(), exp_wr.size());
        for (int i = wr_idx; i < exp_wr.size() && i < act_wr.size(); i++)
            check({tag, "_wraddr"}, act_wr[i], exp_wr[i]);
        wr_idx = exp_wr.size();
        check({tag, "_ferr"}, err_cnt - err_base,
              (part > 0 && nwords == 0 && (op == 1 || op == 3)) ? 1 : 0);
        oe_delta = (sel == 0) ? oe_cnt0 - oe_base0 : oe_cnt1 - oe_base1;
        check({tag, "_oe"}, oe_delta != 0, op == 2 || op == 4);
        check({tag, "_busy"}, busy_cnt - busy_base != 0, sel == 0);
        $display("frame %s sel=%0d cmd=%02h words=%0d part=%0d", tag, sel, cmd, nwords, part);
    endtask

    task automatic do_frame(input string tag, input int sel, input logic [7:0] cmd,
                            input int nwords, input int part);
        frame_pre(sel, cmd, nwords);
        spi_frame(sel, cmd, nwords, part);
        frame_post(tag, sel, cmd, nwords, part);
    endtask

    task automatic host_write(input string tag, input int a, input logic [7:0] d);
        @(negedge clk);
        host_en = 1'b1; host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
        #1;
        check({tag, "_rdy"}, host_ready0, 1);
        @(negedge clk);
        host_en = 1'b0; host_we = 1'b0;
        model[0][a] = d;
        $display("host write %s addr=%0d data=%02h", tag, a, d);
    endtask

    task automatic host_read(input string tag, input int a);
        @(negedge clk);
        host_en = 1'b1; host_we = 1'b0; host_addr = AW'(a);
        #1;
        check({tag, "_rdy"}, host_ready0, 1);
        @(negedge clk);
        host_en = 1'b0;
        check(tag, host_rdata0, model[0][a]);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) host_read($sformatf("%s_m%0d", tag, a), a);
        $display("memory sweep %s done", tag);
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < DEPTH; a++) model[s][a] = '0;

        // Reset values, with a host request pending during reset
        host_en = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_miso",   miso0, 0);
        check("rst_oe",     miso_oe0, 0);
        check("rst_rdata",  host_rdata0, 0);
        check("rst_ready",  host_ready0, 0);
        check("rst_pulse",  spi_wr_pulse0, 0);
        check("rst_wraddr", spi_wr_addr0, 0);
        check("rst_ferr",   frame_err0, 0);
        check("rst_busy",   busy0, 0);
        check("rst_oe1",    miso_oe1, 0);
        check("rst_busy1",  busy1, 0);
        host_en = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", busy0, 0);

        // Single write then single read
        tx_words[0] = 8'h2A;
        do_frame("wr3", 0, 8'h23, 1, 0);
        do_frame("rd3", 0, 8'h43, 1, 0);

        // Burst write across the top address, both wrap modes
        tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
        do_frame("bwr_nowrap", 0, 8'h7E, 3, 0);
        host_read("nowrap30", 30);
        host_read("nowrap31", 31);
        host_read("nowrap0", 0);
        do_frame("bwr_wrap", 1, 8'h7E, 3, 0);
        do_frame("brd_wrap", 1, 8'h9E, 3, 0);
        do_frame("brd_nowrap", 0, 8'h9E, 3, 0);

        // Partial data word is discarded and flagged
        do_frame("partial", 0, 8'h25, 0, 4);
        host_read("partial_m5", 5);
        tx_words[0] = 8'hC3;
        do_frame("after_partial_wr", 0, 8'h25, 1, 0);
        do_frame("after_partial_rd", 0, 8'h45, 1, 0);

        // Host write, SPI read back
        host_write("h7", 7, 8'h5A);
        do_frame("rd7", 0, 8'h47, 1, 0);

        // Host request landing on the SPI commit cycle to the same address
        tx_words[0] = 8'h3C;
        frame_pre(0, 8'h29, 1);
        fork
            spi_frame(0, 8'h29, 1, 0);
            begin
                int k;
                k = 0;
                while (!spi_wr_pulse0 && k < 2000) begin @(negedge clk); k++; end
                check("collide_wait", spi_wr_pulse0, 1);
                host_en = 1'b1; host_we = 1'b1; host_addr = AW'(9); host_wdata = 8'hEE;
                #1;
                check("collide_ready", host_ready0, 0);
                @(negedge clk);
                host_en = 1'b0; host_we = 1'b0;
            end
        join
        frame_post("collide", 0, 8'h29, 1, 0);
        host_read("collide_m9", 9);

        // Invalid opcode followed by two words of clocks
        tx_words[0] = 8'hFF; tx_words[1] = 8'hA5;
        do_frame("invalid", 0, 8'hE4, 2, 0);
        sweep("invalid");

        // Randomized frames and host writes
        for (int n = 0; n < 16; n++) begin
            logic [2:0] op;
            logic [4:0] a5;
            int nw;
            op = 3'($urandom_range(1, 4));
            a5 = 5'($urandom_range(0, DEPTH - 1));
            nw = (op == 3'd1 || op == 3'd2) ? 1 : $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) tx_words[w] = 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                host_write($sformatf("rh%0d", n), $urandom_range(0, DEPTH - 1), 8'($urandom));
            do_frame($sformatf("rnd%0d", n), 0, {op, a5}, nw, 0);
        end
        sweep("random");

        // Reset in the middle of a burst read
        for (int w = 0; w < 4; w++) tx_words[w] = '0;
        fork
            spi_frame(0, 8'h82, 3, 0);
            begin
                int k;
                k = 0;
                while (!miso_oe0 && k < 2000) begin @(negedge clk); k++; end
                check("midrst_oe_before", miso_oe0, 1);
                repeat (20) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("midrst_oe_drop", miso_oe0, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < DEPTH; a++) model[s][a] = '0;
        check("midrst_busy", busy0, 0);
        sweep("midrst");
        tx_words[0] = 8'h96;
        do_frame("post_rst_wr", 0, 8'h3F, 1, 0);
        do_frame("post_rst_rd", 0, 8'h5F, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
